// File: rtl/neuron_argmax.sv
// Sequential argmax over NUM_NEURONS signed scores: capture on in_valid rising edge, one compare per cycle.
// Optional macro ARGMAX_REJECT_EN: report class NUM_NEURONS when the winning score is below REJECT_THRESHOLD.
module neuron_argmax #(
    parameter int                              NUM_NEURONS      = 10,
    parameter int                              OUTPUT_WIDTH     = 26,
    parameter int                              INDEX_WIDTH      = 4,
    parameter logic signed [OUTPUT_WIDTH-1:0]  REJECT_THRESHOLD = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0]   IN_SCORES,
    input  logic                                  in_valid,
    output logic [INDEX_WIDTH-1:0]                CLASS_OUT,
    output logic [OUTPUT_WIDTH-1:0]               MAX_SCORE,
    output logic                                  out_valid,
    output logic                                  busy
);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t                          r_state;
    logic signed [OUTPUT_WIDTH-1:0]  r_scores [NUM_NEURONS];
    logic signed [OUTPUT_WIDTH-1:0]  r_best;
    logic [INDEX_WIDTH-1:0]          r_best_idx;
    logic [INDEX_WIDTH-1:0]          r_idx;
    logic                            r_hist;

    logic                            w_start;
    logic                            w_take;
    logic                            w_last;
    logic signed [OUTPUT_WIDTH-1:0]  w_best_next;
    logic [INDEX_WIDTH-1:0]          w_idx_next;
    logic [INDEX_WIDTH-1:0]          w_class;

    // Strict greater-than keeps the lower index on ties.
    assign w_start     = (r_state == ST_IDLE) && in_valid && !r_hist;
    assign w_take      = r_scores[r_idx] > r_best;
    assign w_best_next = w_take ? r_scores[r_idx] : r_best;
    assign w_idx_next  = w_take ? r_idx : r_best_idx;
    assign w_last      = (r_idx == INDEX_WIDTH'(NUM_NEURONS - 1));

`ifdef ARGMAX_REJECT_EN
    assign w_class = (w_best_next < REJECT_THRESHOLD) ? INDEX_WIDTH'(NUM_NEURONS) : w_idx_next;
`else
    assign w_class = w_idx_next;
    logic w_unused_threshold;
    assign w_unused_threshold = ^REJECT_THRESHOLD;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_hist     <= 1'b0;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            CLASS_OUT  <= '0;
            MAX_SCORE  <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            // NOTE: the score array is a handful of registers, not a RAM, so clearing it on reset is cheap and keeps state deterministic.
            for (int k = 0; k < NUM_NEURONS; k++) r_scores[k] <= '0;
        end else begin
            r_hist    <= in_valid;
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        for (int k = 0; k < NUM_NEURONS; k++)
                            r_scores[k] <= IN_SCORES[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                        r_best     <= IN_SCORES[OUTPUT_WIDTH-1:0];
                        r_best_idx <= '0;
                        r_idx      <= INDEX_WIDTH'(1);
                        busy       <= 1'b1;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_best     <= w_best_next;
                    r_best_idx <= w_idx_next;
                    if (w_last) begin
                        CLASS_OUT <= w_class;
                        MAX_SCORE <= w_best_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_argmax.sv
// Scoreboard bench for neuron_argmax: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_neuron_argmax;

    localparam int N  = 10;
    localparam int W  = 26;
    localparam int IW = 4;
    localparam logic signed [W-1:0] THR = 26'sd262144;

    typedef struct {
        logic [IW-1:0] cls;
        logic [W-1:0]  score;
        int            cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [N*W-1:0]    in_scores;
    logic              in_valid;
    logic [IW-1:0]     class_out;
    logic [W-1:0]      max_score;
    logic              out_valid;
    logic              busy;

    logic signed [W-1:0] sc [N];
    exp_t                q [$];
    int                  cyc = 0;
    int                  n_tests = 0;
    int                  n_fail = 0;
    logic [IW-1:0]       held_cls = '0;
    logic [W-1:0]        held_score = '0;

    neuron_argmax #(
        .NUM_NEURONS(N), .OUTPUT_WIDTH(W), .INDEX_WIDTH(IW), .REJECT_THRESHOLD(THR)
    ) dut (
        .clk(clk), .rst(rst), .IN_SCORES(in_scores), .in_valid(in_valid),
        .CLASS_OUT(class_out), .MAX_SCORE(max_score), .out_valid(out_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_scores();
        for (int k = 0; k < N; k++) in_scores[k*W +: W] = sc[k];
    endtask

    // Reference: find the maximum value, then the lowest index holding it.
    function automatic exp_t model(input int when);
        exp_t r;
        logic signed [W-1:0] m;
        m = sc[0];
        for (int k = 1; k < N; k++) if (sc[k] > m) m = sc[k];
        r.cls = '0;
        for (int k = N - 1; k >= 0; k--) if (sc[k] == m) r.cls = IW'(k);
`ifdef ARGMAX_REJECT_EN
        if (m < THR) r.cls = IW'(N);
`endif
        r.score = m;
        r.cyc   = when;
        return r;
    endfunction

    // Raise in_valid in IDLE; the start edge is the next one, the result pulse nine edges later.
    task automatic start_txn(input bit push_exp);
        pack_scores();
        in_valid = 1'b1;
        if (push_exp) q.push_back(model(cyc + N));
        tick();
    endtask

    task automatic run_txn();
        start_txn(1'b1);
        check("busy_in_scan", busy, 1'b1);
        in_valid = 1'b0;
        repeat (N) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            held_cls   = '0;
            held_score = '0;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("class", class_out, e.cls);
                check("score", max_score, e.score);
                check("latency", cyc, e.cyc);
                held_cls   = e.cls;
                held_score = e.score;
            end
        end else begin
            check("hold_class", class_out, held_cls);
            check("hold_score", max_score, held_score);
        end
    end

    initial begin
        int c;
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        pack_scores();
        repeat (5) tick();
        check("rst_class", class_out, '0);
        check("rst_score", max_score, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);

        // Release with in_valid already high: first edge starts a scan.
        q.push_back(model(cyc + N));
        rst = 1'b1;
        tick();
        check("busy_after_release", busy, 1'b1);
        in_valid = 1'b0;
        repeat (N) tick();

        for (int k = 0; k < N; k++) sc[k] = W'(k * 262144);
        sc[6] = 26'h0F00000;
        run_txn();

        for (int k = 0; k < N; k++) sc[k] = 26'h3FC0000;
        sc[3] = 26'h3FE0000;
        sc[8] = 26'h3FE0000;
        run_txn();

        for (int k = 0; k < N; k++) sc[k] = 26'h2000000;
        sc[N-1] = 26'h1FFFFFF;
        run_txn();

        for (int k = 0; k < N; k++) sc[k] = 26'h0123456;
        run_txn();

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < N; k++)
                sc[k] = (t % 2 == 0) ? W'($urandom) : W'(int'($urandom_range(0, 3)) - 2);
            run_txn();
        end

        // Level in_valid held high, with scores changed mid-scan: one result from captured data.
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        start_txn(1'b1);
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        pack_scores();
        repeat (39) tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Toggle in_valid during a scan and end high: still one result.
        start_txn(1'b1);
        for (int k = 0; k < N; k++) sc[k] = '0;
        pack_scores();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1;
        repeat (15) tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Rise sampled on the completing edge is not a start.
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        c = cyc;
        start_txn(1'b1);
        in_valid = 1'b0;
        while (cyc < c + N - 1) tick();
        in_valid = 1'b1;
        repeat (15) tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Rise sampled on the first IDLE edge after completion does start.
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        c = cyc;
        start_txn(1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        while (cyc < c + N) tick();
        start_txn(1'b1);
        in_valid = 1'b0;
        repeat (N + 2) tick();

        // Mid-scan reset discards the partial result.
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        start_txn(1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_class", class_out, '0);
        check("midrst_score", max_score, '0);
        check("midrst_valid", out_valid, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < N; k++) sc[k] = W'($urandom);
        run_txn();

        // Every score 0.5: below a 1.0 reject threshold when that option is built in.
        for (int k = 0; k < N; k++) sc[k] = 26'h0020000;
        run_txn();
        for (int k = 0; k < N; k++) sc[k] = 26'h0020000;
        sc[4] = 26'h0080000;
        run_txn();

        repeat (15) tick();
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_argmax.md
Name: neuron_argmax

Overview:
- Consumes the per-neuron sums produced by the output layer (NUM_NEURONS neurons, each a signed Q8.18 score) and produces the winning class index.
- Captures all scores on the rising edge of the combined neuron-done signal, then scans them sequentially, one compare per cycle.
- Presents the class index and max score with a one-cycle valid pulse.
- Sits directly downstream of the neuron array, at the top of the classifier datapath.

Parameters:
- NUM_NEURONS, 10, number of scores compared (≥2).
- OUTPUT_WIDTH, 26, width of each signed score (Q8.18 two's complement).
- INDEX_WIDTH, 4, width of the class index; must satisfy 2^INDEX_WIDTH > NUM_NEURONS.
- REJECT_THRESHOLD, 0, signed OUTPUT_WIDTH-bit threshold; used only with ARGMAX_REJECT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- IN_SCORES  input  NUM_NEURONS*OUTPUT_WIDTH  packed scores; neuron k occupies bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- in_valid  input  1  AND of all neuron done flags; level signal that may stay high.
- CLASS_OUT  output  INDEX_WIDTH  winning neuron index; holds between results.
- MAX_SCORE  output  OUTPUT_WIDTH  winning score; holds between results.
- out_valid  output  1  one-cycle pulse when CLASS_OUT/MAX_SCORE update.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, CLASS_OUT=0, MAX_SCORE=0, out_valid=0, busy=0.
  - Scan index cleared; captured scores cleared; in_valid history register=0.
- Start condition: in IDLE and in_valid=1 while history register=0 (rising edge).
  - History register samples in_valid every cycle, in every state.
  - in_valid already high on the first edge after reset release counts as a rising edge and starts a scan.
- IDLE:
  - On start at edge E0: latch all IN_SCORES into an internal array.
  - Set best=score[0], best_idx=0, i=1; go to SCAN; busy=1 from E0.
- SCAN (one compare per cycle):
  - At each edge, if signed score[i] > best (strict), then best=score[i] and best_idx=i.
  - Ties keep the lower index.
  - If i==NUM_NEURONS-1: load CLASS_OUT/MAX_SCORE from the final compare result, out_valid=1, busy=0, go to IDLE.
  - Otherwise i=i+1.
- Latency: out_valid asserts after edge E0+(NUM_NEURONS-1), which is 9 cycles for the default. It deasserts on the next edge.
- in_valid changes during SCAN (fall, rise, glitch) are ignored. Captured data is used and no start is queued. A new start requires a fresh rising edge observed in IDLE.
  - Back-to-back: a rising edge sampled on the same edge that SCAN completes is not a start. The history register still updates on that edge.
- Compare is signed two's complement on the full OUTPUT_WIDTH. No saturation or arithmetic, so no overflow cases.
- Reset asserted mid-scan: immediate return to reset values. The partial result is discarded and out_valid is never raised.
- CLASS_OUT/MAX_SCORE change only on edges where out_valid is raised.

Optional Feature:
- Macro ARGMAX_REJECT_EN.
- Defined:
  - After the final compare, if best < REJECT_THRESHOLD (signed), CLASS_OUT=NUM_NEURONS (reject code, e.g. 10).
  - MAX_SCORE still = best; latency unchanged.
- Undefined: no threshold logic, and REJECT_THRESHOLD is unused. CLASS_OUT is always in 0..NUM_NEURONS-1.

Test Plan:
- Reset check: hold rst=0 with random IN_SCORES and in_valid=1 → outputs all 0, busy=0. Release rst with in_valid=1 → scan starts, out_valid pulses 9 cycles later.
- Unique max: scores k*262144 (k=0..9, i.e. 0.0..9.0), with score[6]=0x0F00000 (60.0). Raise in_valid → exactly 9 cycles later out_valid=1 for one cycle, CLASS_OUT=6, MAX_SCORE=0x0F00000.
- Negatives and ties: all scores −1.0 (0x3FC0000) except score[3]=score[8]=−0.5 (0x3FE0000) → CLASS_OUT=3, MAX_SCORE=0x3FE0000.
- Level in_valid: hold in_valid high for 40 cycles, then toggle it during a scan → exactly one out_valid pulse per rising edge observed in IDLE. Changing IN_SCORES mid-scan does not alter the result.
- Mid-scan reset: assert rst=0 at cycle 4 of SCAN → busy=0, CLASS_OUT=0, no out_valid. A subsequent start yields the correct result.
- With ARGMAX_REJECT_EN and REJECT_THRESHOLD=262144 (1.0): all scores 0.5 → CLASS_OUT=10, MAX_SCORE=0x0020000. Same stimulus without the macro → CLASS_OUT=0.
